// File: rtl/ofm_deskew_fifo_if.sv
// ----------------------------------------------------------------------------
// ofm_deskew_fifo_if
//   Bundles the skewed column stream arriving from the systolic array with the
//   aligned row-vector stream handed to writeback.
//   ofm_vld / ofm          : per-column valid and signed result (array -> block)
//   out_vld / out_rdy      : valid/ready handshake on the aligned head vector
//   out_data               : aligned head row vector (block -> writeback)
//   modport slave  : the deskew FIFO
//   modport master : the surrounding environment (array side + writeback side)
// ----------------------------------------------------------------------------
interface ofm_deskew_fifo_if #(
  parameter int WIDTH  = 16,
  parameter int OWIDTH = 32
);
  logic [WIDTH-1:0]         ofm_vld;
  logic signed [OWIDTH-1:0] ofm      [WIDTH-1:0];
  logic                     out_vld;
  logic                     out_rdy;
  logic signed [OWIDTH-1:0] out_data [WIDTH-1:0];

  modport slave  (input  ofm_vld, ofm, out_rdy, output out_vld, out_data);
  modport master (output ofm_vld, ofm, out_rdy, input  out_vld, out_data);
endinterface

// File: rtl/ofm_deskew_fifo.sv
// ----------------------------------------------------------------------------
// ofm_deskew_fifo
//   Re-aligns the skewed column outputs of the systolic array (column w lags
//   column 0 by w cycles), checks that all aligned lanes agree on validity and
//   buffers complete row vectors in a small show-ahead FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : skewed input columns and aligned output handshake
//   clr_flags   : synchronous clear of the sticky ovf/err flags
//   level       : FIFO occupancy (0..DEPTH)
//   ovf         : sticky, an aligned vector was dropped because the FIFO was full
//   err         : sticky, aligned lane valids disagreed
// ----------------------------------------------------------------------------
module ofm_deskew_fifo #(
  parameter  int WIDTH  = 16,
  parameter  int OWIDTH = 32,
  parameter  int DEPTH  = 4,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  ofm_deskew_fifo_if.slave    bus,
  input  logic                clr_flags,
  output logic [LW-1:0]       level,
  output logic                ovf,
  output logic                err
);

  localparam int PW = $clog2(DEPTH);
  localparam int GW = $clog2(WIDTH) + 1;

  // --------------------------------------------------------------------------
  // Deskew: lane w is delayed by WIDTH-1-w cycles, valid and data together.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]         al_vld;
  logic signed [OWIDTH-1:0] al_data [WIDTH-1:0];

  for (genvar w = 0; w < WIDTH; w++) begin : g_lane
    localparam int D = WIDTH - 1 - w;
    if (D == 0) begin : g_nodelay
      assign al_vld[w]  = bus.ofm_vld[w];
      assign al_data[w] = bus.ofm[w];
    end else begin : g_delay
      logic [D-1:0]             vld_q;
      logic signed [OWIDTH-1:0] dat_q [D];

      // NOTE: sequential state uses non-blocking assignments so every stage of
      // the shift register samples its predecessor's pre-edge value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= bus.ofm_vld[w];
          for (int k = 1; k < D; k++) vld_q[k] <= vld_q[k-1];
        end
      end

      // NOTE: delay-line data is deliberately left unreset; the valid bits
      // travelling alongside are what qualify it.
      always_ff @(posedge clk) begin
        dat_q[0] <= bus.ofm[w];
        for (int k = 1; k < D; k++) dat_q[k] <= dat_q[k-1];
      end

      assign al_vld[w]  = vld_q[D-1];
      assign al_data[w] = dat_q[D-1];
    end
  end

  // --------------------------------------------------------------------------
  // Warm-up guard: for the first WIDTH-1 edges after reset the aligned vector
  // still contains lanes whose lane-0 partner was sampled before reset (and
  // discarded), so those vectors are ignored rather than flagged as errors.
  // --------------------------------------------------------------------------
  logic [GW-1:0] warm_q;
  logic          warm;

  assign warm = (warm_q == GW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     warm_q <= '0;
    else if (!warm) warm_q <= warm_q + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Push decision and FIFO control
  // --------------------------------------------------------------------------
  logic          all_vld, any_vld, push_req, mixed;
  logic          full, pop, push, drop;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d, err_q, err_d;

  logic signed [OWIDTH-1:0] mem_q [DEPTH][WIDTH-1:0];

  assign all_vld  = &al_vld;
  assign any_vld  = |al_vld;
  assign push_req = warm & all_vld;
  assign mixed    = warm & any_vld & ~all_vld;

  assign full = (level_q == LW'(DEPTH));
  assign pop  = (level_q != '0) & bus.out_rdy;
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  // NOTE: every combinational output gets a default first so no latch is
  // inferred on any path through the block.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Set wins over a simultaneous clear.
    ovf_d = drop  | (ovf_q & ~clr_flags);
    err_d = mixed | (err_q & ~clr_flags);
  end

  // NOTE: the storage array is reset (unlike the delay lines) because the
  // head vector is visible on out_data and must read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= al_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.out_vld  = (level_q != '0);
  assign bus.out_data = mem_q[rd_ptr_q];
  assign level        = level_q;
  assign ovf          = ovf_q;
  assign err          = err_q;

endmodule
